// File: rtl/serial_add_ctrl_if.sv
// Request/response bus between a requesting unit and the bit-serial adder sequencer.
interface serial_add_ctrl_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             cin;
    logic             sub;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             cout;

    modport master (
        output start, op_a, op_b, cin, sub,
        input  busy, done, result, cout
    );

    modport slave (
        input  start, op_a, op_b, cin, sub,
        output busy, done, result, cout
    );
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer driving one shared external full-adder cell, LSB first.
// Optional subtract support is built only when SERIAL_ADD_SUB_EN is defined.
module serial_add_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    serial_add_ctrl_if.slave    bus,
    output logic                fa_a,
    output logic                fa_b,
    output logic                fa_cin,
    input  logic                fa_sum,
    input  logic                fa_carry
);

    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
    localparam int unsigned SHW   = WIDTH - 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e           state_q;
    logic [SHW-1:0]   a_q;
    logic [SHW-1:0]   b_q;
    logic [CNT_W-1:0] cnt_q;
    logic             carry_q;
    logic             fa_a_q;
    logic             fa_b_q;
    logic             busy_q;
    logic             done_q;
    logic             cout_q;
    logic [WIDTH-1:0] result_q;

    logic [WIDTH-1:0] b_load_c;
    logic             cin_load_c;
    logic             last_c;

    // Operand B and initial carry as seen by the cell; subtraction folds into a one's-complement load.
`ifdef SERIAL_ADD_SUB_EN
    always_comb begin
        b_load_c   = bus.op_b;
        cin_load_c = bus.cin;
        if (bus.sub) begin
            b_load_c   = ~bus.op_b;
            cin_load_c = 1'b1;
        end
    end
`else
    logic unused_sub;
    assign unused_sub = bus.sub;

    always_comb begin
        b_load_c   = bus.op_b;
        cin_load_c = bus.cin;
    end
`endif

    assign last_c = (cnt_q == CNT_W'(WIDTH - 1));

    // Sequencer: the fa_* drive registers always hold the bit pair for the current RUN cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            fa_a_q   <= 1'b0;
            fa_b_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            cout_q   <= 1'b0;
            result_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        state_q  <= S_RUN;
                        busy_q   <= 1'b1;
                        a_q      <= bus.op_a[WIDTH-1:1];
                        b_q      <= b_load_c[WIDTH-1:1];
                        fa_a_q   <= bus.op_a[0];
                        fa_b_q   <= b_load_c[0];
                        carry_q  <= cin_load_c;
                        cnt_q    <= '0;
                        result_q <= '0;
                        cout_q   <= 1'b0;
                    end
                end
                S_RUN: begin
                    result_q <= {fa_sum, result_q[WIDTH-1:1]};
                    a_q      <= a_q >> 1;
                    b_q      <= b_q >> 1;
                    cnt_q    <= cnt_q + CNT_W'(1);
                    if (last_c) begin
                        carry_q <= 1'b0;
                        fa_a_q  <= 1'b0;
                        fa_b_q  <= 1'b0;
                        cout_q  <= fa_carry;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        carry_q <= fa_carry;
                        fa_a_q  <= a_q[0];
                        fa_b_q  <= b_q[0];
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign fa_a       = fa_a_q;
    assign fa_b       = fa_b_q;
    assign fa_cin     = carry_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;
    assign bus.cout   = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl: arithmetic reference model, per-cycle compare, directed and random ops.
module tb_serial_add_ctrl;

    localparam int unsigned WIDTH = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    serial_add_ctrl_if #(.WIDTH(WIDTH)) bus();

    logic fa_a, fa_b, fa_cin, fa_sum, fa_carry;
    assign fa_sum   = fa_a ^ fa_b ^ fa_cin;
    assign fa_carry = (fa_a & fa_b) | (fa_a & fa_cin) | (fa_b & fa_cin);

    serial_add_ctrl #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .fa_a     (fa_a),
        .fa_b     (fa_b),
        .fa_cin   (fa_cin),
        .fa_sum   (fa_sum),
        .fa_carry (fa_carry)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: phase 0 idle, 1..WIDTH run cycle (bit phase-1), WIDTH+1 done cycle.
    int          phase = 0;
    logic [31:0] m_a = '0;
    logic [31:0] m_b = '0;
    logic [31:0] m_c0 = '0;
    logic [WIDTH:0] m_exp = '0;

    always @(posedge clk or negedge rst_n) begin
        logic [WIDTH-1:0] nb;
        logic [31:0]      tot;
        if (!rst_n) begin
            phase = 0;
            m_exp = '0;
        end else if (phase == 0) begin
            if (bus.start === 1'b1) begin
                m_a  = 32'(bus.op_a);
                m_b  = 32'(bus.op_b);
                m_c0 = 32'(bus.cin);
`ifdef SERIAL_ADD_SUB_EN
                if (bus.sub) begin
                    nb   = ~bus.op_b;
                    m_b  = 32'(nb);
                    m_c0 = 32'd1;
                end
`endif
                tot   = m_a + m_b + m_c0;
                m_exp = tot[WIDTH:0];
                phase = 1;
            end
        end else if (phase == WIDTH + 1) begin
            phase = 0;
        end else begin
            phase++;
        end
    end

    // Per-cycle compare of every DUT output against the model.
    always @(negedge clk) begin
        int          k;
        logic [31:0] mask, csum;
        logic        ea, eb, ec;
        if (rst_n === 1'b1) begin
            ea = 1'b0; eb = 1'b0; ec = 1'b0;
            if (phase >= 1 && phase <= WIDTH) begin
                k    = phase - 1;
                mask = (32'd1 << k) - 32'd1;
                csum = (m_a & mask) + (m_b & mask) + m_c0;
                ea   = m_a[k];
                eb   = m_b[k];
                ec   = csum[k];
            end
            chk("busy", 32'(bus.busy), 32'(phase != 0));
            chk("done", 32'(bus.done), 32'(phase == WIDTH + 1));
            chk("fa_a", 32'(fa_a), 32'(ea));
            chk("fa_b", 32'(fa_b), 32'(eb));
            chk("fa_cin", 32'(fa_cin), 32'(ec));
            if (phase == 0 || phase == WIDTH + 1) begin
                chk("result", 32'(bus.result), 32'(m_exp[WIDTH-1:0]));
                chk("cout", 32'(bus.cout), 32'(m_exp[WIDTH]));
            end
        end
    end

    // One request; reports latency in edges after acceptance, busy cycles and the captured result.
    task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic c, input logic s,
                          output int lat, output int bcnt, output logic post_busy,
                          output logic [WIDTH-1:0] res, output logic co);
        @(negedge clk);
        bus.start = 1'b1; bus.op_a = a; bus.op_b = b; bus.cin = c; bus.sub = s;
        @(negedge clk);
        bus.start = 1'b0;
        bus.op_a = WIDTH'($urandom); bus.op_b = WIDTH'($urandom);
        lat  = 0;
        bcnt = bus.busy ? 1 : 0;
        while (!bus.done && lat < 40) begin
            @(negedge clk);
            lat++;
            if (bus.busy) bcnt++;
        end
        res = bus.result;
        co  = bus.cout;
        @(negedge clk);
        post_busy = bus.busy | bus.done;
    endtask

    initial begin
        int lat, bcnt, rises, last_rise, waitc;
        logic pb, co, prev_busy;
        logic [WIDTH-1:0] res;

        bus.start = 1'b0; bus.op_a = '0; bus.op_b = '0; bus.cin = 1'b0; bus.sub = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_result", 32'(bus.result), 32'd0);
        chk("rst_cout", 32'(bus.cout), 32'd0);
        chk("rst_fa", 32'({fa_a, fa_b, fa_cin}), 32'd0);
        rst_n = 1'b1;

        run_op(8'h5A, 8'h33, 1'b0, 1'b0, lat, bcnt, pb, res, co);
        chk("lat_5a33", 32'(lat), 32'(WIDTH));
        chk("busy_cycles_5a33", 32'(bcnt), 32'(WIDTH + 1));
        chk("post_busy_5a33", 32'(pb), 32'd0);
        chk("res_5a33", 32'(res), 32'h8D);
        chk("cout_5a33", 32'(co), 32'd0);

        run_op(8'hFF, 8'h01, 1'b0, 1'b0, lat, bcnt, pb, res, co);
        chk("res_ff01", 32'(res), 32'h00);
        chk("cout_ff01", 32'(co), 32'd1);
        run_op(8'h00, 8'h00, 1'b1, 1'b0, lat, bcnt, pb, res, co);
        chk("res_cin", 32'(res), 32'h01);
        chk("cout_cin", 32'(co), 32'd0);

`ifdef SERIAL_ADD_SUB_EN
        run_op(8'h10, 8'h01, 1'b0, 1'b1, lat, bcnt, pb, res, co);
        chk("res_sub1", 32'(res), 32'h0F);
        chk("cout_sub1", 32'(co), 32'd1);
        run_op(8'h01, 8'h02, 1'b0, 1'b1, lat, bcnt, pb, res, co);
        chk("res_sub2", 32'(res), 32'hFF);
        chk("cout_sub2", 32'(co), 32'd0);
`else
        run_op(8'h10, 8'h01, 1'b0, 1'b1, lat, bcnt, pb, res, co);
        chk("res_sub_ignored", 32'(res), 32'h11);
        chk("cout_sub_ignored", 32'(co), 32'd0);
`endif

        // Start held high: operands scrambled while busy, restored in the idle slot before each accept.
        @(negedge clk);
        bus.start = 1'b1; bus.op_a = 8'h10; bus.op_b = 8'h20; bus.cin = 1'b0; bus.sub = 1'b0;
        rises = 0; last_rise = -1; prev_busy = 1'b0;
        for (int cyc = 0; cyc < 45; cyc++) begin
            @(negedge clk);
            if (bus.busy && !prev_busy) begin
                if (last_rise >= 0) chk("accept_spacing", 32'(cyc - last_rise), 32'(WIDTH + 2));
                last_rise = cyc;
                rises++;
            end
            if (bus.done) chk("hold_result", 32'(bus.result), 32'h30);
            prev_busy = bus.busy;
            if (bus.busy) begin
                bus.op_a = WIDTH'($urandom); bus.op_b = WIDTH'($urandom);
            end else begin
                bus.op_a = 8'h10; bus.op_b = 8'h20;
            end
        end
        chk("hold_accepts", 32'(rises), 32'd5);
        bus.start = 1'b0;
        waitc = 0;
        while (bus.busy && waitc < 40) begin
            @(negedge clk);
            waitc++;
        end
        chk("hold_drain", 32'(bus.busy), 32'd0);

        // Asynchronous reset in the middle of a run.
        @(negedge clk);
        bus.start = 1'b1; bus.op_a = 8'h12; bus.op_b = 8'h34; bus.cin = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(bus.busy), 32'd0);
        chk("arst_done", 32'(bus.done), 32'd0);
        chk("arst_result", 32'(bus.result), 32'd0);
        chk("arst_cout", 32'(bus.cout), 32'd0);
        chk("arst_fa", 32'({fa_a, fa_b, fa_cin}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(8'h7F, 8'h01, 1'b0, 1'b0, lat, bcnt, pb, res, co);
        chk("res_7f01", 32'(res), 32'h80);
        chk("cout_7f01", 32'(co), 32'd0);

        // Random traffic, checked cycle by cycle by the compare process.
        for (int n = 0; n < 30; n++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            run_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'($urandom),
                   lat, bcnt, pb, res, co);
            chk("rand_lat", 32'(lat), 32'(WIDTH));
        end

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
